// File: rtl/raster_scan_if.sv
// Handshake bundle linking the raster scan controller with the triangle source,
// the three lockstep edge-function units and the fragment sink.
interface raster_scan_if;
  logic        tri_valid;
  logic        tri_ready;
  logic [10:0] v0_x, v0_y, v1_x, v1_y, v2_x, v2_y;
  logic        pix_valid;
  logic        pix_ready;
  logic [10:0] pix_x, pix_y;
  logic        res_valid;
  logic        res_ready;
  logic [2:0]  res_inside;
  logic [10:0] res_x, res_y;
  logic        frag_valid;
  logic        frag_ready;
  logic [10:0] frag_x, frag_y;
  logic        busy;
  logic        tri_done;

  // Controller side
  modport master (
    input  tri_valid, v0_x, v0_y, v1_x, v1_y, v2_x, v2_y,
    input  pix_ready, res_valid, res_inside, res_x, res_y, frag_ready,
    output tri_ready, pix_valid, pix_x, pix_y, res_ready,
    output frag_valid, frag_x, frag_y, busy, tri_done
  );

  // Environment side (triangle source, edge units, fragment sink)
  modport slave (
    output tri_valid, v0_x, v0_y, v1_x, v1_y, v2_x, v2_y,
    output pix_ready, res_valid, res_inside, res_x, res_y, frag_ready,
    input  tri_ready, pix_valid, pix_x, pix_y, res_ready,
    input  frag_valid, frag_x, frag_y, busy, tri_done
  );
endinterface

// File: rtl/raster_scan_ctrl.sv
// Triangle scan scheduler: clips the bounding box to the screen, walks it in raster order
// towards three lockstep edge units and forwards fully covered pixels as fragments.
module raster_scan_ctrl #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic          clk,
  input  logic          reset,
  raster_scan_if.master bus
);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);
  localparam logic signed [11:0] X_LIM = 12'(SCREEN_W - 1);
  localparam logic signed [11:0] Y_LIM = 12'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SCAN, DRAIN} state_t;
  state_t state_reg, state_next;

  logic signed [11:0] vx_reg [3];
  logic signed [11:0] vy_reg [3];
  logic signed [11:0] min_x, max_x, min_y, max_y;
  logic signed [11:0] xmin_c, xmax_c, ymin_c, ymax_c;
  logic               box_empty;

  logic [10:0]   xmin_reg, xmax_reg, ymax_reg, x_reg, y_reg;
  logic [CW-1:0] inflight_reg;
  logic          frag_valid_reg;
  logic [10:0]   frag_x_reg, frag_y_reg;

  logic accept, pix_valid_int, issue, res_ready_int, res_accept, last_pix, tri_done_int;

  assign accept        = bus.tri_valid && (state_reg == IDLE);
  assign pix_valid_int = (state_reg == SCAN) && (inflight_reg < MAX_CNT);
  assign issue         = pix_valid_int && bus.pix_ready;
  assign res_ready_int = !frag_valid_reg || bus.frag_ready;
  assign res_accept    = bus.res_valid && res_ready_int;
  assign last_pix      = (x_reg == xmax_reg) && (y_reg == ymax_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        vx_reg[i] <= '0;
        vy_reg[i] <= '0;
      end
    end else if (accept) begin
      vx_reg[0] <= $signed({bus.v0_x[10], bus.v0_x});
      vy_reg[0] <= $signed({bus.v0_y[10], bus.v0_y});
      vx_reg[1] <= $signed({bus.v1_x[10], bus.v1_x});
      vy_reg[1] <= $signed({bus.v1_y[10], bus.v1_y});
      vx_reg[2] <= $signed({bus.v2_x[10], bus.v2_x});
      vy_reg[2] <= $signed({bus.v2_y[10], bus.v2_y});
    end
  end

  // Screen-clipped bounding box; signed so off-screen vertices clamp correctly.
  always_comb begin
    min_x = vx_reg[0];
    max_x = vx_reg[0];
    min_y = vy_reg[0];
    max_y = vy_reg[0];
    for (int i = 1; i < 3; i++) begin
      if (vx_reg[i] < min_x) min_x = vx_reg[i];
      if (vx_reg[i] > max_x) max_x = vx_reg[i];
      if (vy_reg[i] < min_y) min_y = vy_reg[i];
      if (vy_reg[i] > max_y) max_y = vy_reg[i];
    end
    xmin_c    = (min_x < 12'sd0) ? 12'sd0 : min_x;
    xmax_c    = (max_x > X_LIM)  ? X_LIM  : max_x;
    ymin_c    = (min_y < 12'sd0) ? 12'sd0 : min_y;
    ymax_c    = (max_y > Y_LIM)  ? Y_LIM  : max_y;
    box_empty = (xmin_c > xmax_c) || (ymin_c > ymax_c);
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    tri_done_int = 1'b0;
    case (state_reg)
      IDLE:  if (bus.tri_valid) state_next = SETUP;
      SETUP: state_next = box_empty ? DRAIN : SCAN;
      SCAN:  if (issue && last_pix) state_next = DRAIN;
      DRAIN: begin
        if ((inflight_reg == '0) && !frag_valid_reg) begin
          tri_done_int = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Raster walker: coordinates only move on an accepted issue, so they hold while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      xmin_reg <= '0;
      xmax_reg <= '0;
      ymax_reg <= '0;
      x_reg    <= '0;
      y_reg    <= '0;
    end else if (state_reg == SETUP) begin
      xmin_reg <= xmin_c[10:0];
      xmax_reg <= xmax_c[10:0];
      ymax_reg <= ymax_c[10:0];
      x_reg    <= xmin_c[10:0];
      y_reg    <= ymin_c[10:0];
    end else if (issue) begin
      if (x_reg == xmax_reg) begin
        x_reg <= xmin_reg;
        y_reg <= y_reg + 11'd1;
      end else begin
        x_reg <= x_reg + 11'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_reg <= '0;
    end else begin
      case ({issue, res_accept && (inflight_reg != '0)})
        2'b10:   inflight_reg <= inflight_reg + CW'(1);
        2'b01:   inflight_reg <= inflight_reg - CW'(1);
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  // One-entry fragment buffer; a covered result may replace the entry leaving this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      frag_valid_reg <= 1'b0;
      frag_x_reg     <= '0;
      frag_y_reg     <= '0;
    end else if (res_accept && (bus.res_inside == 3'b111)) begin
      frag_valid_reg <= 1'b1;
      frag_x_reg     <= bus.res_x;
      frag_y_reg     <= bus.res_y;
    end else if (bus.frag_ready) begin
      frag_valid_reg <= 1'b0;
    end
  end

  assign bus.tri_ready  = (state_reg == IDLE);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.pix_valid  = pix_valid_int;
  assign bus.pix_x      = x_reg;
  assign bus.pix_y      = y_reg;
  assign bus.res_ready  = res_ready_int;
  assign bus.frag_valid = frag_valid_reg;
  assign bus.frag_x     = frag_x_reg;
  assign bus.frag_y     = frag_y_reg;
  assign bus.tri_done   = tri_done_int;
endmodule
